// File: rtl/signed_mul_pkg.sv
// rtl/signed_mul_pkg.sv - shared types and constants for the sequential signed/unsigned multiplier
package signed_mul_pkg;

    // Operand width used when the multiplier is instantiated without override.
    localparam int DEFAULT_W = 8;

    // Iteration counter width for the default operand width.
    localparam int CNT_W = $clog2(DEFAULT_W);

    typedef enum logic [2:0] {
        IDLE,
        ABS_A,
        ABS_B,
        MUL,
        FIX
    } state_e;

endpackage

// File: rtl/twos_negate.sv
// rtl/twos_negate.sv - combinational conditional two's-complement negate
// Ports: x  - N-bit input value
//        en - 1 selects ~x + 1 (mod 2^N), 0 passes x through
//        y  - N-bit result
module twos_negate #(
    parameter int N = 16
) (
    input  logic [N-1:0] x,
    input  logic         en,
    output logic [N-1:0] y
);

    assign y = en ? (~x + N'(1)) : x;

endmodule

// File: rtl/signed_mul_seq.sv
// rtl/signed_mul_seq.sv - sequential W x W shift-add multiplier with sign-magnitude handling
// Ports: clk, rst_n (async, active-low)
//        start, signed_mode, a, b - command and operands, sampled while idle
//        busy    - operation in progress
//        done    - one-cycle completion pulse
//        product - 2W-bit result, held until the next done
module signed_mul_seq
    import signed_mul_pkg::*;
#(
    parameter int W = DEFAULT_W
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic           signed_mode,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] product
);

    localparam int CW = (W == DEFAULT_W) ? CNT_W : $clog2(W);

    state_e         state_q,   state_d;
    logic [W-1:0]   a_q,       a_d;
    logic [W-1:0]   b_q,       b_d;
    logic           sm_q,      sm_d;
    logic           neg_q,     neg_d;
    logic [W-1:0]   mag_a_q,   mag_a_d;
    logic [W-1:0]   mulr_q,    mulr_d;
    logic [W:0]     acc_q,     acc_d;
    logic [CW-1:0]  cnt_q,     cnt_d;
    logic           busy_q,    busy_d;
    logic           done_q,    done_d;
    logic [2*W-1:0] product_q, product_d;

    // Shared negator: |a| in ABS_A, |b| in ABS_B, sign restore in FIX.
    logic [2*W-1:0] neg_x;
    logic           neg_en;
    logic [2*W-1:0] neg_y;

    // Upper accumulator is W+1 bits so the add carry survives until the shift.
    logic [W:0]     sum;

    twos_negate #(.N(2*W)) u_negate (
        .x  (neg_x),
        .en (neg_en),
        .y  (neg_y)
    );

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        sm_d      = sm_q;
        neg_d     = neg_q;
        mag_a_d   = mag_a_q;
        mulr_d    = mulr_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        neg_x     = '0;
        neg_en    = 1'b0;
        sum       = acc_q + (mulr_q[0] ? {1'b0, mag_a_q} : {(W+1){1'b0}});

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    sm_d    = signed_mode;
                    neg_d   = signed_mode & (a[W-1] ^ b[W-1]);
                    busy_d  = 1'b1;
                    state_d = ABS_A;
                end
            end
            ABS_A: begin
                // For the most negative value the negate returns the same
                // pattern, which read unsigned is the correct magnitude.
                neg_x   = {{W{a_q[W-1]}}, a_q};
                neg_en  = sm_q & a_q[W-1];
                mag_a_d = neg_y[W-1:0];
                state_d = ABS_B;
            end
            ABS_B: begin
                neg_x   = {{W{b_q[W-1]}}, b_q};
                neg_en  = sm_q & b_q[W-1];
                mulr_d  = neg_y[W-1:0];
                cnt_d   = '0;
                acc_d   = '0;
                state_d = MUL;
            end
            MUL: begin
                {acc_d, mulr_d} = {sum, mulr_q} >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // acc_q[W] is always 0 here, so the magnitude is 2W bits.
                neg_x     = {acc_q[W-1:0], mulr_q};
                neg_en    = neg_q;
                product_d = neg_y;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            sm_q      <= 1'b0;
            neg_q     <= 1'b0;
            mag_a_q   <= '0;
            mulr_q    <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            sm_q      <= sm_d;
            neg_q     <= neg_d;
            mag_a_q   <= mag_a_d;
            mulr_q    <= mulr_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_signed_mul_seq.sv
// tb/tb_signed_mul_seq.sv - self-checking bench for signed_mul_seq
module tb_signed_mul_seq;

    localparam int W       = 8;
    localparam int LATENCY = W + 3;

    logic           clk;
    logic           rst_n;
    logic           start;
    logic           signed_mode;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    logic [2*W-1:0] exp_q[$];
    int             n_checks;
    int             n_fail;

    signed_mul_seq #(.W(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [2*W-1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                              input logic sm);
        int p;
        if (sm) p = int'($signed(x)) * int'($signed(y));
        else    p = int'({24'b0, x}) * int'({24'b0, y});
        return p[2*W-1:0];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after an edge; drives a start so the next edge accepts it.
    task automatic start_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                            input logic sm);
        start       = 1'b1;
        a           = x;
        b           = y;
        signed_mode = sm;
        exp_q.push_back(model(x, y, sm));
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy"}, {31'b0, busy}, 32'd1);
    endtask

    // Counts edges after the accepting edge until done, then scoreboards product.
    task automatic wait_done(input string tag, input int already);
        int             edges;
        logic [2*W-1:0] e;
        edges = already;
        while (edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
            if (done) break;
        end
        chk({tag, "_latency"}, edges, LATENCY);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_product"}, {16'b0, product}, {16'b0, e});
        end
        chk({tag, "_busy_low"}, {31'b0, busy}, 32'd0);
    endtask

    initial begin
        logic [2*W-1:0] first;
        n_checks    = 0;
        n_fail      = 0;
        start       = 1'b0;
        signed_mode = 1'b0;
        a           = '0;
        b           = '0;
        rst_n       = 1'b0;
        #23;
        chk("reset_busy", {31'b0, busy}, 32'd0);
        chk("reset_done", {31'b0, done}, 32'd0);
        chk("reset_product", {16'b0, product}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);

        start_op("s3xm5", 8'h03, 8'hFB, 1'b1);
        wait_done("s3xm5", 0);
        chk("s3xm5_const", {16'b0, product}, 32'h0000FFF1);
        idle(1);
        chk("single_pulse", {31'b0, done}, 32'd0);

        start_op("s80x80", 8'h80, 8'h80, 1'b1);
        wait_done("s80x80", 0);
        chk("s80x80_const", {16'b0, product}, 32'h00004000);
        idle(1);
        start_op("s80x01", 8'h80, 8'h01, 1'b1);
        wait_done("s80x01", 0);
        idle(1);
        start_op("uFFxFF", 8'hFF, 8'hFF, 1'b0);
        wait_done("uFFxFF", 0);
        chk("uFFxFF_const", {16'b0, product}, 32'h0000FE01);
        idle(1);
        start_op("sFFxFF", 8'hFF, 8'hFF, 1'b1);
        wait_done("sFFxFF", 0);
        idle(2);

        // Start pulsed mid-operation must be ignored.
        start_op("ign", 8'h12, 8'h34, 1'b0);
        idle(3);
        start       = 1'b1;
        a           = 8'h55;
        b           = 8'h66;
        signed_mode = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("ign_no_done", {31'b0, done}, 32'd0);
        wait_done("ign", 4);
        idle(1);
        chk("ign_single_done", {31'b0, done}, 32'd0);
        chk("ign_no_restart", {31'b0, busy}, 32'd0);
        idle(1);

        // Back-to-back: second start presented during the done cycle.
        start_op("b2b_1", 8'h7F, 8'h81, 1'b1);
        wait_done("b2b_1", 0);
        first = product;
        start_op("b2b_2", 8'h05, 8'hFD, 1'b1);
        chk("b2b_hold", {16'b0, product}, {16'b0, first});
        wait_done("b2b_2", 0);
        idle(1);

        start_op("zero_a", 8'h00, 8'hF9, 1'b1);
        wait_done("zero_a", 0);
        idle(1);
        start_op("zero_b", 8'hF9, 8'h00, 1'b1);
        wait_done("zero_b", 0);
        idle(1);
        start_op("s9Cx07", 8'h9C, 8'h07, 1'b1);
        wait_done("s9Cx07", 0);
        idle(1);

        // Asynchronous reset in the middle of an operation.
        start_op("rst_op", 8'h0D, 8'h0B, 1'b0);
        idle(5);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_product", {16'b0, product}, 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        chk("post_rst_idle", {31'b0, busy}, 32'd0);
        start_op("post_rst", 8'h02, 8'h03, 1'b0);
        wait_done("post_rst", 0);
        chk("post_rst_const", {16'b0, product}, 32'h00000006);
        chk("sb_drained", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/signed_mul_seq.md
Name: signed_mul_seq

Overview:
- Sequential W x W multiplier, signed or unsigned. Uses the shift-add method with sign-magnitude pre- and post-processing.
- One shared two's-complement negate unit is time-multiplexed by the FSM:
  - once to take |a|,
  - once to take |b|,
  - once to restore the sign of the product.
- Sits beside the ALU datapath as its multiply resource. Command interface is start/busy/done.

Parameters:
W, 8, operand width in bits; product is 2W bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while busy=0
- signed_mode  input  1  1 = operands are two's complement; 0 = unsigned. Sampled with start.
- a  input  W  multiplicand; sampled with start
- b  input  W  multiplier; sampled with start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse; product is valid from this cycle onward
- product  output  2W  result register; holds its value until the next done

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
  - Reset values: state=IDLE, busy=0, done=0, product=0, all internal registers 0.
  - Reset asserted mid-operation aborts immediately. product is not updated.
- FSM states: IDLE, ABS_A, ABS_B, MUL, FIX.
  - IDLE: done=0 unless entered from FIX.
    - On start=1: latch a, b and signed_mode.
    - Record neg = signed_mode & (a[W-1] ^ b[W-1]).
    - Go to ABS_A; busy=1.
  - ABS_A: negator input = sign_ext(a), enable = signed_mode & a[W-1]. Register low W bits as mag_a. Go to ABS_B.
  - ABS_B: same as ABS_A for b, giving mag_b. Clear cnt and acc. Go to MUL.
  - MUL: W iterations, one per clock.
    - If the LSB of the multiplier shift register is 1, add mag_a to the upper half of acc. The upper half is W+1 bits to keep the carry.
    - Then shift {acc, multiplier} right by 1.
    - cnt increments each iteration. After cnt reaches W-1, go to FIX.
  - FIX: negator input = the 2W accumulated magnitude, enable = neg. Register the result into product. Set done=1, busy=0, go to IDLE.
- Latency: done is high in the cycle after clock edge W+3, counted from the edge that accepted start. That is 11 edges for W=8.
- Back-to-back: start is accepted in the same IDLE cycle that done=1. The next operation begins without a bubble; product keeps the old value until the new done.
- start while busy=1: ignored, not queued.
- Boundary: a or b = 100…0 in signed mode.
  - The negator returns the same bit pattern, which is correctly interpreted as the unsigned magnitude 2^(W-1).
  - No overflow is possible: the signed product always fits in 2W bits (-128 x -128 = 16384).
  - No overflow output exists.
- Zero operand: the result is 0 and must never come out as negative zero. Negating 0 yields 0, so this holds when neg=1.
- Negator arithmetic: y = en ? (~x + 1) mod 2^(2W) : x. It is purely combinational.

Decomposition:
- Package signed_mul_pkg holds:
  - the state enum (IDLE, ABS_A, ABS_B, MUL, FIX),
  - the default W,
  - the counter width constant CNT_W = $clog2(W).
- One sub-module: twos_negate, parameterised width N, instantiated once with N=2W. Ports x[N], en, y[N]. It is the shared negate resource.
- FSM, counter, accumulator and registers live in signed_mul_seq.

Test Plan:
- Signed, a=3, b=-5 (0xFB), start pulse → busy=1 next cycle; done pulse after edge 11; product=0xFFF1 (-15).
- Signed, a=0x80, b=0x80 → product=0x4000 (16384). Signed, a=0x80, b=0x01 → product=0xFF80.
- Unsigned, a=0xFF, b=0xFF → product=0xFE01. Signed, same operands → product=0x0001.
- start pulsed again at edge 4 of an operation, with different operands → ignored. Single done; product matches the first operands only.
- Back-to-back: start held high with new operands in the done cycle → second done exactly 11 edges later.
- Zero case: a=0, b=-7 → product=0x0000.
- rst_n driven low at edge 6 of an operation → busy, done and product go to 0 asynchronously. After release, a fresh 2 x 3 gives product=0x0006.
